// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit
//   Registered shift/rotate unit driven by asynchronous push buttons.
//   A WIDTH-bit working register is loaded from `data` and, on each
//   synchronised rising edge of BTNR/BTNL, shifted or rotated by one
//   position (two when BTNC is held), one bit per step tick.
//
// Ports
//   clk    : sole clock
//   reset  : synchronous, active-high reset
//   data   : parallel load value
//   load   : load `data` into the working register (aborts any shift)
//   BTNR   : right-shift request (asynchronous)
//   BTNL   : left-shift request (asynchronous)
//   BTNC   : double-step modifier, sampled at request acceptance
//   mode   : 00 rotate, 01 logical, 10 arithmetic, 11 rotate
//   shout  : working register
//   busy   : high while a shift is in progress
//   done   : one-cycle pulse after the final step
//
// Optional feature: define AUTO_REPEAT_EN to enable hold-to-repeat on
// BTNR/BTNL (first repeat after REPEAT_DELAY hold cycles, then every
// REPEAT_RATE cycles).
module shift_rotate_unit #(
  parameter int WIDTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int STEP_DIV     = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             BTNR,
  input  logic             BTNL,
  input  logic             BTNC,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shout,
  output logic             busy,
  output logic             done
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Button index: 0 = right, 1 = left, 2 = centre (modifier)
  logic [2:0]                  btn_raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]                  synced;
  logic [1:0]                  prev_q, prev_d;
  logic [1:0]                  rise;
  logic [1:0]                  rep;
  logic [1:0]                  req;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shout_q, shout_d;
  logic [WIDTH-1:0] stepped;
  logic [1:0]       steps_q, steps_d;
  logic [PW-1:0]    prescale_q, prescale_d;
  logic             dir_left_q, dir_left_d;
  logic [1:0]       mode_q, mode_d;
  logic             done_q, done_d;
  logic             accept;
  logic             step_tick;

  assign btn_raw = {BTNC, BTNL, BTNR};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
    prev_d = synced[1:0];
    rise   = synced[1:0] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);

  logic [1:0][HW-1:0] hold_q, hold_d;
  logic               both_held;

  // The counter register never holds REPEAT_DELAY itself: the repeat fires
  // on the increment that would reach it, and the counter reloads instead.
  always_comb begin
    both_held = synced[0] & synced[1];
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = hold_q[i];
      rep[i]    = 1'b0;
      if (!synced[i] || rise[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] == HW'(REPEAT_DELAY - 1)) begin
        hold_d[i] = HW'(REPEAT_DELAY - REPEAT_RATE);
        rep[i]    = ~both_held;
      end else begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign rep = 2'b00;
`endif

  assign req       = rise | rep;
  // Simultaneous left and right requests cancel each other.
  assign accept    = (state_q == IDLE) && (req[0] ^ req[1]);
  assign step_tick = (state_q == SHIFT) && (prescale_q == PW'(STEP_DIV - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT:   if (step_tick && steps_q == 2'd1) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // One single-bit step of the working register in the captured mode.
  always_comb begin
    case (mode_q)
      2'b01:   stepped = dir_left_q ? {shout_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shout_q[WIDTH-1:1]};
      2'b10:   stepped = dir_left_q ? {shout_q[WIDTH-2:0], 1'b0}
                                    : {shout_q[WIDTH-1], shout_q[WIDTH-1:1]};
      default: stepped = dir_left_q ? {shout_q[WIDTH-2:0], shout_q[WIDTH-1]}
                                    : {shout_q[0], shout_q[WIDTH-1:1]};
    endcase
  end

  // Datapath and request capture
  always_comb begin
    shout_d    = shout_q;
    steps_d    = steps_q;
    prescale_d = prescale_q;
    dir_left_d = dir_left_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    if (load) begin
      shout_d    = data;
      steps_d    = '0;
      prescale_d = '0;
    end else if (accept) begin
      dir_left_d = req[1];
      steps_d    = synced[2] ? 2'd2 : 2'd1;
      mode_d     = mode;
      prescale_d = '0;
    end else if (state_q == SHIFT) begin
      if (step_tick) begin
        shout_d    = stepped;
        prescale_d = '0;
        steps_d    = steps_q - 2'd1;
        done_d     = (steps_q == 2'd1);
      end else begin
        prescale_d = prescale_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shout_q    <= '0;
      steps_q    <= '0;
      prescale_q <= '0;
      dir_left_q <= 1'b0;
      mode_q     <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shout_q    <= shout_d;
      steps_q    <= steps_d;
      prescale_q <= prescale_d;
      dir_left_q <= dir_left_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

  // Outputs
  always_comb begin
    shout = shout_q;
    busy  = (state_q == SHIFT);
    done  = done_q;
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
module tb_shift_rotate_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic        BTNR = 1'b0;
  logic        BTNL = 1'b0;
  logic        BTNC = 1'b0;
  logic [1:0]  mode = 2'b00;

  logic [15:0] shout1, shout4;
  logic        busy1, busy4, done1, done4;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shift_rotate_unit #(.WIDTH(16), .SYNC_STAGES(2), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .data(data), .load(load),
    .BTNR(BTNR), .BTNL(BTNL), .BTNC(BTNC), .mode(mode),
    .shout(shout1), .busy(busy1), .done(done1)
  );

  shift_rotate_unit #(.WIDTH(16), .SYNC_STAGES(2), .STEP_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .data(data), .load(load),
    .BTNR(BTNR), .BTNL(BTNL), .BTNC(BTNC), .mode(mode),
    .shout(shout4), .busy(busy4), .done(done4)
  );

  // Reference: n single-bit operations computed with plain shifts.
  function automatic logic [15:0] model(input logic [15:0] v, input bit left,
                                        input logic [1:0] m, input int n);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      if (m == 2'b01)      r = left ? (r << 1) : (r >> 1);
      else if (m == 2'b10) r = left ? (r << 1) : 16'($signed(r) >>> 1);
      else                 r = left ? ((r << 1) | (r >> 15)) : ((r >> 1) | (r << 15));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    data = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Press r/l for a few cycles with BTNC already settled, then observe.
  task automatic pulse(input logic r, input logic l, input logic c,
                       output int d1, output int d4);
    BTNC = c;
    repeat (3) tick();
    BTNR = r;
    BTNL = l;
    d1 = 0;
    d4 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) begin
        BTNR = 1'b0;
        BTNL = 1'b0;
      end
      d1 += int'(done1);
      d4 += int'(done4);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total_cnt++; if (shout1 !== 16'h0) $display("FAIL reset_shout1 got %h exp 0000", shout1); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else pass_cnt++;
    total_cnt++; if (done1 !== 1'b0) $display("FAIL reset_done1 got %b exp 0", done1); else pass_cnt++;
    total_cnt++; if (shout4 !== 16'h0) $display("FAIL reset_shout4 got %h exp 0000", shout4); else pass_cnt++;
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL reset_busy4 got %b exp 0", busy4); else pass_cnt++;
    reset = 1'b0;
    repeat (3) tick();
    $display("reset: shout1=%h busy1=%b done1=%b", shout1, busy1, done1);
  endtask

  task automatic test_rotate_right_latency();
    do_load(16'h8001);
    total_cnt++; if (shout1 !== 16'h8001) $display("FAIL load_8001 got %h exp 8001", shout1); else pass_cnt++;
    mode = 2'b00;
    BTNC = 1'b0;
    repeat (3) tick();
    BTNR = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (shout1 !== 16'h8001) $display("FAIL ror_edge3_shout got %h exp 8001", shout1); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b1) $display("FAIL ror_edge3_busy got %b exp 1", busy1); else pass_cnt++;
    tick();
    total_cnt++; if (shout1 !== 16'hC000) $display("FAIL ror_edge4_shout got %h exp c000", shout1); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b0) $display("FAIL ror_edge4_busy got %b exp 0", busy1); else pass_cnt++;
    total_cnt++; if (done1 !== 1'b1) $display("FAIL ror_edge4_done got %b exp 1", done1); else pass_cnt++;
    BTNR = 1'b0;
    tick();
    total_cnt++; if (done1 !== 1'b0) $display("FAIL ror_done_width got %b exp 0", done1); else pass_cnt++;
    repeat (10) tick();
    $display("rotate right 1: shout1=%h", shout1);
  endtask

  task automatic test_rotate_left_double();
    int d1, d4, b1;
    do_load(16'h8001);
    mode = 2'b00;
    BTNC = 1'b1;
    repeat (3) tick();
    BTNL = 1'b1;
    d1 = 0; d4 = 0; b1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) BTNL = 1'b0;
      d1 += int'(done1);
      d4 += int'(done4);
      b1 += int'(busy1);
    end
    total_cnt++; if (shout1 !== 16'h0006) $display("FAIL rol2_shout got %h exp 0006", shout1); else pass_cnt++;
    total_cnt++; if (b1 != 2) $display("FAIL rol2_busy_cycles got %0d exp 2", b1); else pass_cnt++;
    total_cnt++; if (d1 != 1) $display("FAIL rol2_done_count got %0d exp 1", d1); else pass_cnt++;
    total_cnt++; if (shout4 !== 16'h0006) $display("FAIL rol2_shout4 got %h exp 0006", shout4); else pass_cnt++;
    $display("rotate left 2: shout1=%h busy_cycles=%0d dones=%0d", shout1, b1, d1);
  endtask

  task automatic test_arith_logical();
    int d1, d4;
    do_load(16'h8000);
    mode = 2'b10;
    pulse(1'b1, 1'b0, 1'b1, d1, d4);
    total_cnt++; if (shout1 !== 16'hE000) $display("FAIL asr2_shout got %h exp e000", shout1); else pass_cnt++;
    $display("arith right 2: shout1=%h", shout1);
    do_load(16'h8000);
    mode = 2'b01;
    pulse(1'b1, 1'b0, 1'b1, d1, d4);
    total_cnt++; if (shout1 !== 16'h2000) $display("FAIL lsr2_shout got %h exp 2000", shout1); else pass_cnt++;
    total_cnt++; if (shout4 !== 16'h2000) $display("FAIL lsr2_shout4 got %h exp 2000", shout4); else pass_cnt++;
    $display("logical right 2: shout1=%h", shout1);
  endtask

  task automatic test_simultaneous();
    int d1, d4;
    do_load(16'hA5C3);
    mode = 2'b00;
    pulse(1'b1, 1'b1, 1'b0, d1, d4);
    total_cnt++; if (shout1 !== 16'hA5C3) $display("FAIL both_shout got %h exp a5c3", shout1); else pass_cnt++;
    total_cnt++; if (d1 != 0) $display("FAIL both_done got %0d exp 0", d1); else pass_cnt++;
    total_cnt++; if (d4 != 0) $display("FAIL both_done4 got %0d exp 0", d4); else pass_cnt++;
    $display("simultaneous: shout1=%h dones=%0d", shout1, d1);
  endtask

  task automatic test_busy_drop();
    int d1, d4;
    do_load(16'h1234);
    mode = 2'b00;
    BTNC = 1'b1;
    repeat (3) tick();
    BTNL = 1'b1;
    d1 = 0; d4 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 2) begin
        BTNL = 1'b0;
        BTNR = 1'b1;
      end
      if (i == 5) BTNR = 1'b0;
      d1 += int'(done1);
      d4 += int'(done4);
    end
    total_cnt++; if (shout4 !== model(16'h1234, 1'b1, 2'b00, 2)) $display("FAIL drop_shout4 got %h exp %h", shout4, model(16'h1234, 1'b1, 2'b00, 2)); else pass_cnt++;
    total_cnt++; if (d4 != 1) $display("FAIL drop_done4 got %0d exp 1", d4); else pass_cnt++;
    // The fast instance is idle again before the right press rises.
    total_cnt++; if (shout1 !== 16'h1234) $display("FAIL drop_shout1 got %h exp 1234", shout1); else pass_cnt++;
    total_cnt++; if (d1 != 2) $display("FAIL drop_done1 got %0d exp 2", d1); else pass_cnt++;
    $display("busy drop: shout4=%h dones4=%0d shout1=%h dones1=%0d", shout4, d4, shout1, d1);
  endtask

  task automatic test_load_abort();
    int d4;
    do_load(16'h00F0);
    mode = 2'b00;
    BTNC = 1'b1;
    repeat (3) tick();
    BTNR = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (busy4 !== 1'b1) $display("FAIL abort_busy_shift1 got %b exp 1", busy4); else pass_cnt++;
    tick();
    data = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    BTNR = 1'b0;
    total_cnt++; if (shout4 !== 16'h1234) $display("FAIL abort_shout got %h exp 1234", shout4); else pass_cnt++;
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy4); else pass_cnt++;
    d4 = int'(done4);
    for (int i = 0; i < 25; i++) begin
      tick();
      d4 += int'(done4);
    end
    total_cnt++; if (d4 != 0) $display("FAIL abort_done got %0d exp 0", d4); else pass_cnt++;
    total_cnt++; if (shout4 !== 16'h1234) $display("FAIL abort_hold got %h exp 1234", shout4); else pass_cnt++;
    $display("load abort: shout4=%h dones4=%0d", shout4, d4);
  endtask

  task automatic test_auto_repeat();
    int d1, d4, e1, e4;
    logic [15:0] s1, s4;
`ifdef AUTO_REPEAT_EN
    e1 = 4; s1 = 16'h0010;
    e4 = 3; s4 = 16'h0008;  // the repeat at t12 lands while the slow unit is busy
`else
    e1 = 1; s1 = 16'h0002;
    e4 = 1; s4 = 16'h0002;
`endif
    do_load(16'h0001);
    mode = 2'b00;
    BTNC = 1'b0;
    repeat (3) tick();
    BTNL = 1'b1;
    d1 = 0; d4 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 16) BTNL = 1'b0;
      d1 += int'(done1);
      d4 += int'(done4);
    end
    total_cnt++; if (d1 != e1) $display("FAIL repeat_done1 got %0d exp %0d", d1, e1); else pass_cnt++;
    total_cnt++; if (shout1 !== s1) $display("FAIL repeat_shout1 got %h exp %h", shout1, s1); else pass_cnt++;
    total_cnt++; if (d4 != e4) $display("FAIL repeat_done4 got %0d exp %0d", d4, e4); else pass_cnt++;
    total_cnt++; if (shout4 !== s4) $display("FAIL repeat_shout4 got %h exp %h", shout4, s4); else pass_cnt++;
    $display("hold: shout1=%h dones1=%0d shout4=%h dones4=%0d", shout1, d1, shout4, d4);
  endtask

  task automatic test_random();
    int d1, d4;
    logic [15:0] v, exp_v;
    logic [1:0]  m;
    bit          left, dbl;
    for (int it = 0; it < 8; it++) begin
      v    = 16'($urandom);
      m    = 2'($urandom_range(0, 3));
      left = 1'($urandom_range(0, 1));
      dbl  = 1'($urandom_range(0, 1));
      do_load(v);
      mode = m;
      pulse(!left, left, dbl, d1, d4);
      exp_v = model(v, left, m, dbl ? 2 : 1);
      total_cnt++; if (shout1 !== exp_v) $display("FAIL rand%0d_shout1 got %h exp %h", it, shout1, exp_v); else pass_cnt++;
      total_cnt++; if (shout4 !== exp_v) $display("FAIL rand%0d_shout4 got %h exp %h", it, shout4, exp_v); else pass_cnt++;
      total_cnt++; if (d1 != 1) $display("FAIL rand%0d_done1 got %0d exp 1", it, d1); else pass_cnt++;
      total_cnt++; if (d4 != 1) $display("FAIL rand%0d_done4 got %0d exp 1", it, d4); else pass_cnt++;
      $display("rand%0d: v=%h mode=%0d left=%0d dbl=%0d shout1=%h shout4=%h", it, v, m, left, dbl, shout1, shout4);
    end
  endtask

  initial begin
    test_reset();
    test_rotate_right_latency();
    test_rotate_left_double();
    test_arith_logical();
    test_simultaneous();
    test_busy_drop();
    test_load_abort();
    test_auto_repeat();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
